// File: rtl/pipe_skid_register.sv
// Two-entry elastic pipeline register with a registered in_ready and a skid slot.
// Optional stall statistics counter enabled by `PIPE_SKID_STATS_EN`.
module pipe_skid_register #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [15:0]      stall_cnt
`endif
);

  // state | meaning
  // EMPTY | no words held
  // BUSY  | main valid, skid free
  // FULL  | main and skid valid, upstream blocked
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] skid, skid_nxt, main_nxt;
  logic             in_ready_nxt, out_valid_nxt;
  logic             in_xfer, out_xfer;

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= EMPTY;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      skid      <= '0;
    end else begin
      state     <= state_nxt;
      in_ready  <= in_ready_nxt;
      out_valid <= out_valid_nxt;
      out_data  <= main_nxt;
      skid      <= skid_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    main_nxt  = out_data;
    skid_nxt  = skid;
    case (state)
      EMPTY: begin
        if (in_xfer) begin
          main_nxt  = in_data;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (in_xfer && out_xfer) begin
          main_nxt = in_data;
        end else if (in_xfer) begin
          skid_nxt  = in_data;
          state_nxt = FULL;
        end else if (out_xfer) begin
          state_nxt = EMPTY;
        end
      end
      FULL: begin
        if (out_xfer) begin
          main_nxt  = skid;
          state_nxt = BUSY;
        end
      end
      default: state_nxt = EMPTY;
    endcase
    // Flags follow the next state so in_ready drops on the edge that enters FULL.
    in_ready_nxt  = (state_nxt != FULL);
    out_valid_nxt = (state_nxt != EMPTY);
  end

`ifdef PIPE_SKID_STATS_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 16'h0000;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/pipe_skid_register.md
# pipe_skid_register

Two-entry elastic pipeline register with valid/ready handshaking on both sides. It is the consuming, back-pressure-aware counterpart to the plain same-cycle pipeline register. Upstream writes are accepted only when the block is ready, and a downstream stage reads at its own pace. When downstream stalls, the skid entry absorbs one in-flight word, so `in_ready` can be a pure flop output and no combinational path runs from `out_ready` to `in_ready`.

## Interface
- `WIDTH`, 32, data width in bits.
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  asynchronous, active-low reset (asserted when 0).
- `in_valid`  input  1  upstream word present.
- `in_ready`  output  1  block can accept a word; registered.
- `in_data`  input  WIDTH  upstream word.
- `out_valid`  output  1  `out_data` holds a word; registered.
- `out_ready`  input  1  downstream takes the word this cycle.
- `out_data`  output  WIDTH  head word; registered.
- `stall_cnt`  output  16  downstream stall cycles (only with `PIPE_SKID_STATS_EN`).

## Operation
- Handshake rules:
  - Transfer in: `in_valid && in_ready` at a rising edge.
  - Transfer out: `out_valid && out_ready` at a rising edge.
- Storage: `main` drives `out_data`; `skid` holds the overflow word.
- FSM states: EMPTY (no words), BUSY (`main` valid), FULL (`main` and `skid` valid).
  - EMPTY: on in-transfer, `main <= in_data` and go to BUSY.
  - BUSY, in-transfer and out-transfer: `main <= in_data`, stay in BUSY.
  - BUSY, in-transfer only: `skid <= in_data`, go to FULL.
  - BUSY, out-transfer only: go to EMPTY.
  - BUSY, neither: hold.
  - FULL: `in_ready` is 0. On out-transfer, `main <= skid` and go to BUSY; otherwise hold.
- `out_valid` is 1 in BUSY and FULL.
- `in_ready` is 1 in EMPTY and BUSY, and 0 in FULL.
- `in_ready` is registered next-state logic: it deasserts in the same edge that enters FULL.
- Ordering: words leave in acceptance order; none are dropped or duplicated.
- Stalls:
  - `out_data` and `out_valid` are held stable while `out_valid && !out_ready`.
  - `in_valid` without `in_ready` has no effect; `in_data` is ignored.
- Reset (`reset` = 0, asynchronous):
  - State goes to EMPTY.
  - `in_ready` = 0, `out_valid` = 0.
  - `out_data` = 0 and `skid` = 0.
  - `stall_cnt` = 0.
- Reset release: `in_ready` rises at the first rising edge after `reset` returns to 1. A reset mid-transfer discards both stored words.

## Timing
- Latency: a word accepted at edge N appears on `out_data` with `out_valid` = 1 after edge N (one cycle).
- Throughput: one word per cycle when `out_ready` is held at 1.
- Stall recovery: after FULL, one out-transfer returns the block to BUSY and re-raises `in_ready` on that same edge.
- Paths: no combinational path from any input to any output.

## Configuration
- Macro: `PIPE_SKID_STATS_EN`.
- Defined:
  - `stall_cnt` port exists.
  - It increments by 1 on every edge where `out_valid && !out_ready`.
  - It saturates at 16'hFFFF and clears only on reset.
- Undefined: the `stall_cnt` port and its counter logic are absent; handshake behaviour is identical.

## Test plan
- Reset release:
  - Stimulus: hold `reset` = 0 for 3 cycles, then release.
  - Required response: `in_ready` = 0, `out_valid` = 0 and `out_data` = 0 during reset; `in_ready` = 1 one edge after release.
- Streaming:
  - Stimulus: `out_ready` = 1; drive 8'h01..8'h08 (`WIDTH` = 8) on consecutive cycles.
  - Required response: `out_data` shows 01..08 on consecutive cycles, each one cycle after its input; `in_ready` stays 1.
- Stall into FULL:
  - Stimulus: `out_ready` = 0; drive A5, then 5A.
  - Required response: `out_data` = A5 is held; `in_ready` = 0 after the second accept; a third word C3 held on `in_data` is not accepted.
- Drain from FULL:
  - Stimulus: from the previous state, pulse `out_ready` for 1 cycle.
  - Required response: `out_data` = 5A and `in_ready` = 1 on the next edge; C3 is accepted next and the order A5, 5A, C3 is preserved.
- Reset mid-operation:
  - Stimulus: assert `reset` while in FULL, asynchronously with respect to `clk`.
  - Required response: `out_valid` = 0 immediately; no old word appears after release.
- Statistics (`PIPE_SKID_STATS_EN` defined):
  - Stimulus: stall for 5 cycles with `out_valid` = 1.
  - Required response: `stall_cnt` = 5; `stall_cnt` forced to FFFF stays at FFFF on a further stall.
